shifter_arbiter: RTL and testbench

Shares one Shifter64X32 instance between NREQ requesters, for example the integer pipes of several cores.
- Arbitration is round-robin; winning operands are registered and driven onto the shifter inputs with a one-cycle ACT pulse.
- Requester ID and destination tag travel through a LAT-deep tag pipe alongside the shifter.
- Results and flags go into an output FIFO with a valid/ready interface.
- Issue is credit-gated, so no result is ever lost while the shifter runs without stall.

---
 rtl/shifter_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_shifter_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// Round-robin front end that shares one multi-cycle shifter among NREQ requesters.
// A tag pipe carries requester ID and destination alongside the shifter; results land in a credit-guarded FIFO.
module shifter_arbiter #(
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int LAT    = 3,
    parameter int FDEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic [NREQ*64-1:0]   req_a_i,
    input  logic [NREQ*6-1:0]    req_b_i,
    input  logic [NREQ*7-1:0]    req_c_i,
    input  logic [NREQ*64-1:0]   req_d_i,
    input  logic [NREQ*5-1:0]    req_dst_i,
    input  logic [NREQ*2-1:0]    req_sa_i,
    input  logic [NREQ*2-1:0]    req_sd_i,
    input  logic [NREQ*3-1:0]    req_opr_i,
    output logic                 sh_act_o,
    output logic [63:0]          sh_a_o,
    output logic [5:0]           sh_b_o,
    output logic [6:0]           sh_c_o,
    output logic [63:0]          sh_d_o,
    output logic [1:0]           sh_sa_o,
    output logic [1:0]           sh_sd_o,
    output logic [2:0]           sh_opr_o,
    output logic [4:0]           sh_dsti_o,
    input  logic [63:0]          sh_r_i,
    input  logic                 sh_ovr_i,
    input  logic                 sh_zero_i,
    input  logic                 sh_cout_i,
    input  logic                 sh_sign_i,
    output logic                 res_valid_o,
    input  logic                 res_rdy_i,
    output logic [IDW-1:0]       res_id_o,
    output logic [4:0]           res_dst_o,
    output logic [63:0]          res_r_o,
    output logic [3:0]           res_flags_o,
    output logic                 busy_o
);
    localparam int CW = $clog2(FDEPTH + 1);
    localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int FW = IDW + 5 + 64 + 4;

    logic [63:0] a_arr [NREQ];
    logic [5:0]  b_arr [NREQ];
    logic [6:0]  c_arr [NREQ];
    logic [63:0] d_arr [NREQ];
    logic [4:0]  dst_arr [NREQ];
    logic [1:0]  sa_arr [NREQ];
    logic [1:0]  sd_arr [NREQ];
    logic [2:0]  opr_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]   = req_a_i[gi*64 +: 64];
            assign b_arr[gi]   = req_b_i[gi*6 +: 6];
            assign c_arr[gi]   = req_c_i[gi*7 +: 7];
            assign d_arr[gi]   = req_d_i[gi*64 +: 64];
            assign dst_arr[gi] = req_dst_i[gi*5 +: 5];
            assign sa_arr[gi]  = req_sa_i[gi*2 +: 2];
            assign sd_arr[gi]  = req_sd_i[gi*2 +: 2];
            assign opr_arr[gi] = req_opr_i[gi*3 +: 3];
        end
    endgenerate

    logic [NREQ-1:0] gnt_q, gnt_d, elig;
    logic [IDW-1:0]  ptr_q, ptr_d, win_id;
    logic            win_found, credit_ok, issue, push, pop;
    logic            sh_act_q;
    logic [63:0]     sh_a_q, sh_d_q;
    logic [5:0]      sh_b_q;
    logic [6:0]      sh_c_q;
    logic [1:0]      sh_sa_q, sh_sd_q;
    logic [2:0]      sh_opr_q;
    logic [LAT:0]    tag_v_q;
    logic [IDW-1:0]  tag_id_q [LAT+1];
    logic [4:0]      tag_dst_q [LAT+1];
    logic [CW-1:0]   inflight_q, inflight_d, occ_q, occ_d;
    logic [CW:0]     credit_sum;
    logic [FW-1:0]   mem_q [FDEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

    // A requester granted last cycle may still hold REQ while it reacts, so it is masked.
    assign elig = req_i & ~gnt_q;

    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!win_found && elig[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    assign credit_sum = {1'b0, inflight_q} + {1'b0, occ_q};
    assign credit_ok  = credit_sum < (CW+1)'(FDEPTH);
    assign issue      = credit_ok && win_found;
    assign push       = tag_v_q[LAT];
    assign pop        = (occ_q != '0) && res_rdy_i;

    always_comb begin
        gnt_d = '0;
        if (issue) gnt_d[win_id] = 1'b1;
        ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;
        inflight_d = inflight_q;
        if (issue && !push) inflight_d = inflight_q + 1'b1;
        else if (!issue && push) inflight_d = inflight_q - 1'b1;
        occ_d = occ_q;
        if (push && !pop) occ_d = occ_q + 1'b1;
        else if (!push && pop) occ_d = occ_q - 1'b1;
        wr_ptr_d = (wr_ptr_q == PW'(FDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = (rd_ptr_q == PW'(FDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            gnt_q      <= '0;
            ptr_q      <= '0;
            sh_act_q   <= 1'b0;
            sh_a_q     <= '0;
            sh_b_q     <= '0;
            sh_c_q     <= '0;
            sh_d_q     <= '0;
            sh_sa_q    <= '0;
            sh_sd_q    <= '0;
            sh_opr_q   <= '0;
            tag_v_q    <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int k = 0; k <= LAT; k++) begin
                tag_id_q[k]  <= '0;
                tag_dst_q[k] <= '0;
            end
            for (int k = 0; k < FDEPTH; k++) mem_q[k] <= '0;
        end else begin
            gnt_q    <= gnt_d;
            sh_act_q <= issue;
            tag_v_q  <= {tag_v_q[LAT-1:0], issue};
            if (issue) begin
                ptr_q        <= ptr_d;
                sh_a_q       <= a_arr[win_id];
                sh_b_q       <= b_arr[win_id];
                sh_c_q       <= c_arr[win_id];
                sh_d_q       <= d_arr[win_id];
                sh_sa_q      <= sa_arr[win_id];
                sh_sd_q      <= sd_arr[win_id];
                sh_opr_q     <= opr_arr[win_id];
                tag_id_q[0]  <= win_id;
                tag_dst_q[0] <= dst_arr[win_id];
            end
            for (int k = 1; k <= LAT; k++) begin
                tag_id_q[k]  <= tag_id_q[k-1];
                tag_dst_q[k] <= tag_dst_q[k-1];
            end
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {tag_id_q[LAT], tag_dst_q[LAT], sh_r_i,
                                    sh_ovr_i, sh_zero_i, sh_cout_i, sh_sign_i};
                wr_ptr_q        <= wr_ptr_d;
            end
            if (pop) rd_ptr_q <= rd_ptr_d;
        end
    end

    // Credit gating makes this unreachable; firing means the accounting is broken.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                    !(push && occ_q == CW'(FDEPTH)));

    assign gnt_o       = gnt_q;
    assign sh_act_o    = sh_act_q;
    assign sh_a_o      = sh_a_q;
    assign sh_b_o      = sh_b_q;
    assign sh_c_o      = sh_c_q;
    assign sh_d_o      = sh_d_q;
    assign sh_sa_o     = sh_sa_q;
    assign sh_sd_o     = sh_sd_q;
    assign sh_opr_o    = sh_opr_q;
    assign sh_dsti_o   = '0;
    assign res_valid_o = (occ_q != '0);
    assign {res_id_o, res_dst_o, res_r_o, res_flags_o} = mem_q[rd_ptr_q];
    assign busy_o      = (inflight_q != '0) || (occ_q != '0);
endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter: a behavioural LAT-stage shifter stand-in feeds results back,
// expectations are queued at grant time and compared as the FIFO head is popped.
module tb_shifter_arbiter;
    localparam int NREQ = 4, IDW = 2, LAT = 3, FDEPTH = 4;

    logic clk, reset_n;
    logic [NREQ-1:0] req, gnt;
    logic [NREQ*64-1:0] req_a, req_d;
    logic [NREQ*6-1:0] req_b;
    logic [NREQ*7-1:0] req_c;
    logic [NREQ*5-1:0] req_dst;
    logic [NREQ*2-1:0] req_sa, req_sd;
    logic [NREQ*3-1:0] req_opr;
    logic sh_act;
    logic [63:0] sh_a, sh_d, sh_r;
    logic [5:0] sh_b;
    logic [6:0] sh_c;
    logic [1:0] sh_sa, sh_sd;
    logic [2:0] sh_opr;
    logic [4:0] sh_dsti;
    logic sh_ovr, sh_zero, sh_cout, sh_sign;
    logic res_valid, res_rdy, busy;
    logic [IDW-1:0] res_id;
    logic [4:0] res_dst;
    logic [63:0] res_r;
    logic [3:0] res_flags;

    shifter_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .FDEPTH(FDEPTH)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .gnt_o(gnt),
        .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_d_i(req_d),
        .req_dst_i(req_dst), .req_sa_i(req_sa), .req_sd_i(req_sd), .req_opr_i(req_opr),
        .sh_act_o(sh_act), .sh_a_o(sh_a), .sh_b_o(sh_b), .sh_c_o(sh_c), .sh_d_o(sh_d),
        .sh_sa_o(sh_sa), .sh_sd_o(sh_sd), .sh_opr_o(sh_opr), .sh_dsti_o(sh_dsti),
        .sh_r_i(sh_r), .sh_ovr_i(sh_ovr), .sh_zero_i(sh_zero), .sh_cout_i(sh_cout), .sh_sign_i(sh_sign),
        .res_valid_o(res_valid), .res_rdy_i(res_rdy), .res_id_o(res_id), .res_dst_o(res_dst),
        .res_r_o(res_r), .res_flags_o(res_flags), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter stand-in: size 8<<SA; 000 SHL, 001 SHR, 101 ASR; other codes mix every operand field.
    function automatic logic [67:0] shift_model(input logic [63:0] a, input logic [5:0] b,
            input logic [6:0] c, input logic [63:0] d, input logic [1:0] sa,
            input logic [1:0] sd, input logic [2:0] opr);
        logic [63:0] mask, ax, r;
        logic signed [63:0] s;
        logic cout, ovr;
        int w;
        w    = 8 << sa;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        ax   = a & mask;
        cout = 1'b0;
        ovr  = 1'b0;
        case (opr)
            3'b000: begin
                r = (ax << b) & mask;
                if (b != 0 && int'(b) <= w) cout = ax[w - int'(b)];
            end
            3'b001: begin
                r = ax >> b;
                if (b != 0) cout = ax[int'(b) - 1];
            end
            3'b101: begin
                s = ax[w-1] ? (ax | ~mask) : ax;
                r = 64'(s >>> b) & mask;
                if (b != 0) cout = ax[int'(b) - 1];
            end
            default: begin
                r   = ((a ^ d) + 64'({c, sd, b})) & mask;
                ovr = ^sd;
            end
        endcase
        return {r, ovr, (r == 64'd0), cout, r[w-1]};
    endfunction

    logic [67:0] stub_q [LAT];
    always @(posedge clk) begin
        stub_q[0] <= sh_act ? shift_model(sh_a, sh_b, sh_c, sh_d, sh_sa, sh_sd, sh_opr) : 68'd0;
        for (int k = 1; k < LAT; k++) stub_q[k] <= stub_q[k-1];
    end
    assign {sh_r, sh_ovr, sh_zero, sh_cout, sh_sign} = stub_q[LAT-1];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     dst;
        logic [63:0]    r;
        logic [3:0]     flags;
    } exp_t;

    exp_t sb[$];
    int grant_log[$];
    int checks = 0, failures = 0, cycle = 0, grants = 0, pops = 0;
    logic [NREQ-1:0] prev_gnt = '0;

    logic [63:0] op_a [NREQ];
    logic [63:0] op_d [NREQ];
    logic [5:0]  op_b [NREQ];
    logic [6:0]  op_c [NREQ];
    logic [4:0]  op_dst [NREQ];
    logic [1:0]  op_sa [NREQ];
    logic [1:0]  op_sd [NREQ];
    logic [2:0]  op_opr [NREQ];
    int          left [NREQ];

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req[i]             = (left[i] > 0);
            req_a[i*64 +: 64]  = op_a[i];
            req_b[i*6 +: 6]    = op_b[i];
            req_c[i*7 +: 7]    = op_c[i];
            req_d[i*64 +: 64]  = op_d[i];
            req_dst[i*5 +: 5]  = op_dst[i];
            req_sa[i*2 +: 2]   = op_sa[i];
            req_sd[i*2 +: 2]   = op_sd[i];
            req_opr[i*3 +: 3]  = op_opr[i];
        end
    endtask

    task automatic set_op(input int i, input logic [63:0] a, input logic [5:0] b, input logic [6:0] c,
            input logic [63:0] d, input logic [4:0] dst, input logic [1:0] sa,
            input logic [1:0] sd, input logic [2:0] opr);
        op_a[i] = a; op_b[i] = b; op_c[i] = c; op_d[i] = d;
        op_dst[i] = dst; op_sa[i] = sa; op_sd[i] = sd; op_opr[i] = opr;
    endtask

    task automatic new_op(input int i);
        logic [2:0] opr;
        case ($urandom_range(0, 4))
            0: opr = 3'b000;
            1: opr = 3'b001;
            2: opr = 3'b101;
            3: opr = 3'b010;
            default: opr = 3'b110;
        endcase
        set_op(i, {$urandom, $urandom}, 6'($urandom), 7'($urandom), {$urandom, $urandom},
               5'($urandom), 2'($urandom), 2'($urandom), opr);
    endtask

    // Commits the current cycle: checks a pending pop, crosses the edge, then handles any grant.
    task automatic step();
        exp_t e;
        int gid;
        logic [67:0] m;
        if (res_valid === 1'b1 && res_rdy === 1'b1) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL pop_unexpected: got id=%0d dst=%0d r=%h, required no result", res_id, res_dst, res_r);
            end else begin
                e = sb.pop_front();
                if ({res_id, res_dst, res_r, res_flags} !== {e.id, e.dst, e.r, e.flags}) begin
                    failures++;
                    $display("FAIL result: got id=%0d dst=%0d r=%h flags=%b, required id=%0d dst=%0d r=%h flags=%b",
                             res_id, res_dst, res_r, res_flags, e.id, e.dst, e.r, e.flags);
                end
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (gnt === '0) begin
            checks++;
            if (sh_act !== 1'b0) begin
                failures++;
                $display("FAIL act_idle: got sh_act=%b, required 0 at cycle %0d", sh_act, cycle);
            end
        end else begin
            gid = 0;
            for (int i = 0; i < NREQ; i++) if (gnt[i] === 1'b1) gid = i;
            checks++;
            if ($countones(gnt) != 1 || left[gid] <= 0 || (gnt & prev_gnt) != '0) begin
                failures++;
                $display("FAIL gnt_legal: got gnt=%b prev=%b req=%b, required one-hot on a requesting, unmasked requester",
                         gnt, prev_gnt, req);
            end
            checks++;
            if ({sh_act, sh_a, sh_b, sh_c, sh_d, sh_sa, sh_sd, sh_opr, sh_dsti} !==
                {1'b1, op_a[gid], op_b[gid], op_c[gid], op_d[gid], op_sa[gid], op_sd[gid], op_opr[gid], 5'd0}) begin
                failures++;
                $display("FAIL operands: got act=%b a=%h b=%0d c=%0d d=%h opr=%b, required act=1 a=%h b=%0d c=%0d d=%h opr=%b",
                         sh_act, sh_a, sh_b, sh_c, sh_d, sh_opr, op_a[gid], op_b[gid], op_c[gid], op_d[gid], op_opr[gid]);
            end
            m       = shift_model(op_a[gid], op_b[gid], op_c[gid], op_d[gid], op_sa[gid], op_sd[gid], op_opr[gid]);
            e.id    = IDW'(gid);
            e.dst   = op_dst[gid];
            e.r     = m[67:4];
            e.flags = m[3:0];
            sb.push_back(e);
            grant_log.push_back(gid);
            grants++;
            left[gid]--;
            if (left[gid] > 0) new_op(gid);
            drive_reqs();
        end
        prev_gnt = gnt;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        res_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            set_op(i, 64'd0, 6'd0, 7'd0, 64'd0, 5'd0, 2'd0, 2'd0, 3'd0);
        end
        drive_reqs();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        grant_log.delete();
        prev_gnt = '0;
        cycle = 0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < NREQ; i++) if (left[i] > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int limit);
        int n;
        res_rdy = 1'b1;
        n = 0;
        while (!(sb.size() == 0 && all_done() && busy === 1'b0 && res_valid === 1'b0) && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (!(sb.size() == 0 && busy === 1'b0 && res_valid === 1'b0)) begin
            failures++;
            $display("FAIL %s_drain: got busy=%b valid=%b pending=%0d after %0d cycles, required idle",
                     name, busy, res_valid, sb.size(), n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({gnt, sh_act} !== '0) begin
            failures++;
            $display("FAIL %s_gnt_act: got gnt=%b act=%b, required 0", name, gnt, sh_act);
        end
        checks++;
        if ({sh_a, sh_b, sh_c, sh_d, sh_sa, sh_sd, sh_opr, sh_dsti} !== '0) begin
            failures++;
            $display("FAIL %s_sh_ops: got a=%h b=%0d d=%h opr=%b, required 0", name, sh_a, sh_b, sh_d, sh_opr);
        end
        checks++;
        if ({res_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL %s_valid_busy: got valid=%b busy=%b, required 0", name, res_valid, busy);
        end
        checks++;
        if ({res_id, res_dst, res_r, res_flags} !== '0) begin
            failures++;
            $display("FAIL %s_head: got id=%0d dst=%0d r=%h flags=%b, required 0", name, res_id, res_dst, res_r, res_flags);
        end
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_single_op();
        do_reset();
        res_rdy = 1'b1;
        set_op(1, 64'h1, 6'd4, 7'd0, 64'd0, 5'd7, 2'b11, 2'b00, 3'b000);
        left[1] = 1;
        drive_reqs();
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c == 1) begin
                checks++;
                if (gnt !== 4'b0010) begin
                    failures++;
                    $display("FAIL single_gnt: got gnt=%b, required 0010", gnt);
                end
            end
            if (c <= 4) begin
                checks++;
                if (res_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL single_early: got valid=%b at cycle %0d, required 0", res_valid, c);
                end
            end
            if (c == 5) begin
                checks++;
                if ({res_valid, res_r, res_id, res_dst} !== {1'b1, 64'h10, 2'd1, 5'd7}) begin
                    failures++;
                    $display("FAIL single_result: got valid=%b r=%h id=%0d dst=%0d, required valid=1 r=10 id=1 dst=7",
                             res_valid, res_r, res_id, res_dst);
                end
            end
            if (c == 6) begin
                checks++;
                if ({busy, res_valid} !== 2'b00) begin
                    failures++;
                    $display("FAIL single_busy: got busy=%b valid=%b, required 0", busy, res_valid);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int n;
        do_reset();
        res_rdy = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 2;
            new_op(i);
        end
        drive_reqs();
        wait_idle("rr", 200);
        checks++;
        if (grant_log.size() != 8) begin
            failures++;
            $display("FAIL rr_count: got %0d grants, required 8", grant_log.size());
        end
        n = (grant_log.size() < 8) ? grant_log.size() : 8;
        for (int k = 0; k < n; k++) begin
            checks++;
            if (grant_log[k] != k % NREQ) begin
                failures++;
                $display("FAIL rr_order: grant %0d got requester %0d, required %0d", k, grant_log[k], k % NREQ);
            end
        end
    endtask

    task automatic test_backpressure();
        int g0;
        do_reset();
        res_rdy = 1'b0;
        left[0] = 1000;
        new_op(0);
        drive_reqs();
        g0 = grants;
        repeat (20) step();
        checks++;
        if (grants - g0 != FDEPTH || res_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL bp_limit: got %0d grants valid=%b busy=%b, required %0d grants valid=1 busy=1",
                     grants - g0, res_valid, busy, FDEPTH);
        end
        res_rdy = 1'b1;
        step();
        res_rdy = 1'b0;
        repeat (10) step();
        checks++;
        if (grants - g0 != FDEPTH + 1) begin
            failures++;
            $display("FAIL bp_one_more: got %0d grants, required %0d", grants - g0, FDEPTH + 1);
        end
        left[0] = 1;
        wait_idle("bp", 100);
    endtask

    task automatic test_push_pop();
        int g0, g3, p0, n;
        do_reset();
        res_rdy = 1'b0;
        left[1] = 3;
        new_op(1);
        drive_reqs();
        g0 = grants;
        n = 0;
        while (grants - g0 < 3 && n < 50) begin
            step();
            n++;
        end
        g3 = cycle;
        while (cycle < g3 + LAT && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (grants - g0 != 3 || sb.size() != 3 || res_valid !== 1'b1) begin
            failures++;
            $display("FAIL pp_setup: got grants=%0d valid=%b, required 3 grants valid=1", grants - g0, res_valid);
        end
        res_rdy = 1'b1;
        step();
        res_rdy = 1'b0;
        repeat (3) step();
        checks++;
        if (sb.size() == 0 || {res_valid, res_id, res_dst, res_r} !== {1'b1, sb[0].id, sb[0].dst, sb[0].r}) begin
            failures++;
            $display("FAIL pp_head: got valid=%b r=%h, required second result at head", res_valid, res_r);
        end
        p0 = pops;
        wait_idle("pp", 50);
        checks++;
        if (pops - p0 != 2) begin
            failures++;
            $display("FAIL pp_occ: got %0d entries drained, required 2", pops - p0);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        res_rdy = 1'b1;
        left[2] = 1;
        left[3] = 1;
        new_op(2);
        new_op(3);
        drive_reqs();
        step();
        step();
        checks++;
        if (grants != 0 && grant_log.size() != 2) begin
            failures++;
            $display("FAIL mid_issue: got %0d grants, required 2", grant_log.size());
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        sb.delete();
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        drive_reqs();
        check_reset_outputs("mid_reset");
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (res_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL mid_ghost: got valid=%b busy=%b at cycle %0d after reset, required 0", res_valid, busy, c);
            end
        end
    endtask

    task automatic test_flags();
        int n;
        do_reset();
        res_rdy = 1'b1;
        set_op(0, 64'h80, 6'd1, 7'd0, 64'd0, 5'd3, 2'b00, 2'b00, 3'b101);
        left[0] = 1;
        drive_reqs();
        n = 0;
        while (res_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if ({res_valid, res_r[7:0], res_flags} !== {1'b1, 8'hC0, 4'b0001}) begin
            failures++;
            $display("FAIL flags_asr: got valid=%b r=%h flags=%b, required valid=1 r[7:0]=c0 flags=0001",
                     res_valid, res_r[7:0], res_flags);
        end
        wait_idle("flags", 20);
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 6;
            new_op(i);
        end
        drive_reqs();
        n = 0;
        while (!all_done() && n < 400) begin
            res_rdy = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        wait_idle("b2b", 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_push_pop();
        test_reset_midflight();
        test_flags();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
